// File: rtl/mode_seq_ctrl.sv
// Mode sequencer for the clock/timer display path: forward/back button stepping with
// wrap-around, adjust-activity restart and idle auto-return to normal run mode.
//
//  mode          | meaning
//  --------------+-------------------------------------------
//  0             | normal run, idle counter parked at 0
//  1..NUM_MODES-1| adjust modes, idle counter counts 1 Hz ticks
module mode_seq_ctrl #(
    parameter int NUM_MODES = 4,
    parameter int MODE_W    = 2,
    parameter int TIMEOUT   = 20,
    parameter int CNT_W     = 5
) (
    input  logic              ckht,
    input  logic              rst,
    input  logic              ena_db,
    input  logic              back_db,
    input  logic              adj_act,
    input  logic              tick_1hz,
    output logic [MODE_W-1:0] mode,
    output logic              in_set,
    output logic              mode_chg,
    output logic              tmo_evt,
    output logic [CNT_W-1:0]  idle_cnt
);

    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);

    logic              ena_q;
    logic              back_q;
    logic              nxt_p;
    logic              prv_p;
    logic [MODE_W-1:0] mode_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              tmo_hit;

    always_comb begin
        nxt_p    = ena_db & ~ena_q;
        prv_p    = back_db & ~back_q;
        mode_nxt = mode;
        cnt_nxt  = idle_cnt;
        tmo_hit  = 1'b0;
        if (nxt_p && prv_p) begin
            cnt_nxt = '0;
        end else if (nxt_p) begin
            mode_nxt = (mode == MODE_LAST) ? '0 : mode + 1'b1;
            cnt_nxt  = '0;
        end else if (prv_p) begin
            mode_nxt = (mode == '0) ? MODE_LAST : mode - 1'b1;
            cnt_nxt  = '0;
        end else if (adj_act) begin
            cnt_nxt = '0;
        end else if (tick_1hz && (mode != '0)) begin
            // Timeout only reachable when no button edge or adjust activity is present.
            if (idle_cnt == CNT_LAST) begin
                mode_nxt = '0;
                cnt_nxt  = '0;
                tmo_hit  = 1'b1;
            end else begin
                cnt_nxt = idle_cnt + 1'b1;
            end
        end
    end

    // Button history resets high so a button held through reset is not a press.
    always_ff @(negedge ckht or negedge rst) begin
        if (!rst) begin
            mode     <= '0;
            idle_cnt <= '0;
            mode_chg <= 1'b0;
            tmo_evt  <= 1'b0;
            ena_q    <= 1'b1;
            back_q   <= 1'b1;
        end else begin
            ena_q    <= ena_db;
            back_q   <= back_db;
            mode     <= mode_nxt;
            idle_cnt <= cnt_nxt;
            mode_chg <= (mode_nxt != mode);
            tmo_evt  <= tmo_hit;
        end
    end

    assign in_set = (mode != '0);

endmodule

// File: doc/mode_seq_ctrl.md
Name: mode_seq_ctrl

Overview:
- Parametrised mode sequencer for the clock/timer display path.
- Steps through NUM_MODES modes (0 = normal run, 1..NUM_MODES-1 = adjust modes) on debounced forward/back buttons.
- Detects button edges internally and keeps its own idle-timeout counter driven by the 1 Hz tick.
- Auto-returns to mode 0 after TIMEOUT idle seconds; drives the mode-select of the display mux and the adjust logic.

Parameters:
- NUM_MODES, 4, number of modes; legal range 2..2^MODE_W.
- MODE_W, 2, width of the mode output.
- TIMEOUT, 20, idle seconds in a non-zero mode before auto-return to mode 0; legal range 1..2^CNT_W-1.
- CNT_W, 5, width of the idle counter.

Ports:
- ckht  input  1  system clock; all registers update on its falling edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- ena_db  input  1  debounced "next mode" button level.
- back_db  input  1  debounced "previous mode" button level.
- adj_act  input  1  single-cycle pulse from the adjust logic on any value change; restarts the idle timer.
- tick_1hz  input  1  single-cycle 1 Hz strobe.
- mode  output  MODE_W  current mode.
- in_set  output  1  high when mode != 0.
- mode_chg  output  1  one-cycle pulse in the cycle after mode changes for any reason.
- tmo_evt  output  1  one-cycle pulse in the cycle after an auto-return.
- idle_cnt  output  CNT_W  current idle-second count.

Behaviour:
- Reset (rst=0, asynchronous): mode=0, idle_cnt=0, mode_chg=0, tmo_evt=0, and both edge-history registers=1. The history reset value means a button held through reset release does not register as a press.
- Edge detect: nxt_p = ena_db & ~ena_q; prv_p = back_db & ~back_q. ena_q and back_q register the inputs every cycle. A held button yields exactly one press.
- Next-mode priority, evaluated each falling edge:
  1. nxt_p & prv_p: mode unchanged; idle_cnt=0.
  2. nxt_p: mode = (mode==NUM_MODES-1) ? 0 : mode+1; idle_cnt=0.
  3. prv_p: mode = (mode==0) ? NUM_MODES-1 : mode-1; idle_cnt=0.
  4. adj_act: mode unchanged; idle_cnt=0.
  5. tick_1hz & mode!=0 & idle_cnt==TIMEOUT-1: mode=0; idle_cnt=0; tmo_evt=1 in the next cycle.
  6. tick_1hz & mode!=0: idle_cnt+1.
  7. Otherwise: hold.
- A press always beats a timeout in the same cycle. A timeout never fires while a button edge or adj_act is present.
- In mode 0, idle_cnt is held at 0, and ticks and adj_act are ignored.
- Arithmetic is unsigned. mode never takes values >= NUM_MODES. Wrap-around is explicit, not modulo 2^MODE_W, so non-power-of-2 NUM_MODES are handled.
- Pulse outputs:
  - mode_chg is registered: it is high for exactly one cycle after any cycle in which mode's next value differs from its current value, including wrap and timeout.
  - A press that lands in the same mode (only possible when NUM_MODES=1, which is illegal) gives no pulse.
- in_set is combinational from mode. No latency beyond one clock for mode.
- Reset mid-operation: immediate return to mode 0 with counters cleared; pulses are dropped.

Test Plan:
- Reset, then hold ena_db=1 for 10 cycles, release, press again → mode 0→1 once (not 10), then 1→2; mode_chg pulses once per press.
- NUM_MODES=4, four ena_db presses from 0 → mode 1,2,3,0 (wrap). One back_db press from 0 → mode 3.
- Mode 2, no activity, 20 tick_1hz strobes → idle_cnt 0..19, then on the 20th tick mode=0, tmo_evt=1 for 1 cycle, idle_cnt=0.
- Mode 1, 19 ticks, then adj_act, then 19 more ticks → still mode 1 with idle_cnt=19. Tick 20 after adj_act → mode 0.
- Same cycle ena_db rising edge and 20th tick in mode 1 → mode=2, idle_cnt=0, no tmo_evt. Same cycle ena_db and back_db edges → mode unchanged.
- NUM_MODES=3, MODE_W=2: next from mode 2 → 0 (never 3). Assert rst=0 asynchronously mid-count in mode 2 → mode=0, idle_cnt=0 immediately without a clock edge.
